// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin sharing of the single write port between
// ALU/CSR (req0) and load (req1) results, plus a pending-write scoreboard for issue stalls.
module rf_wb_arbiter #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            iss_valid,
   input  logic [4:0]      iss_rs1,
   input  logic [4:0]      iss_rs2,
   input  logic [4:0]      iss_rd,
   output logic            stall,
   input  logic            req0_valid,
   input  logic [4:0]      req0_rd,
   input  logic [XLEN-1:0] req0_data,
   input  logic            req1_valid,
   input  logic [4:0]      req1_rd,
   input  logic [XLEN-1:0] req1_data,
   output logic            req0_ready,
   output logic            req1_ready,
   output logic            reg_write,
   output logic [4:0]      wr_addr,
   output logic [XLEN-1:0] write_data_reg_file
);

   logic [31:0]     r_pending;
   logic            r_last_grant;

   logic            w_grant0;
   logic            w_grant1;
   logic            w_fire;
   logic [4:0]      w_sel_rd;
   logic [XLEN-1:0] w_sel_data;
   logic            w_issue;
   logic [31:0]     w_pending_nxt;

   // Hazard check uses only committed scoreboard state; no bypass from writes in flight.
   assign stall = !rst && iss_valid &&
                  (r_pending[iss_rs1] | r_pending[iss_rs2] | r_pending[iss_rd]);
   assign w_issue = iss_valid && !stall;

   // On a tie, the requester that did not win last time gets the grant.
   assign w_grant0 = req0_valid && (!req1_valid || r_last_grant);
   assign w_grant1 = req1_valid && (!req0_valid || !r_last_grant);

   assign req0_ready = !rst && w_grant0;
   assign req1_ready = !rst && w_grant1;
   assign w_fire     = w_grant0 || w_grant1;

   assign w_sel_rd   = w_grant1 ? req1_rd   : req0_rd;
   assign w_sel_data = w_grant1 ? req1_data : req0_data;

   // NOTE: every bit gets a default before the conditional updates, so no latch is inferred.
   always_comb begin
      w_pending_nxt = r_pending;
      if (reg_write)
         w_pending_nxt[wr_addr] = 1'b0;
      // Set is applied after clear so it wins if both ever hit the same index.
      if (w_issue && (iss_rd != 5'd0))
         w_pending_nxt[iss_rd] = 1'b1;
      w_pending_nxt[0] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending           <= '0;
         r_last_grant        <= 1'b1;
         reg_write           <= 1'b0;
         wr_addr             <= 5'd0;
         write_data_reg_file <= '0;
      end else begin
         r_pending <= w_pending_nxt;
         if (w_fire) begin
            r_last_grant        <= w_grant1;
            reg_write           <= (w_sel_rd != 5'd0);
            wr_addr             <= w_sel_rd;
            write_data_reg_file <= w_sel_data;
         end else begin
            reg_write <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Table-driven bench for rf_wb_arbiter: combinational outputs are checked per vector,
// registered writeback outputs via a scoreboard queue one cycle later.
module tb_rf_wb_arbiter;

   typedef struct {
      logic        rst;
      logic        r0v;
      logic [4:0]  r0rd;
      logic [31:0] r0d;
      logic        r1v;
      logic [4:0]  r1rd;
      logic [31:0] r1d;
      logic        iv;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        e0;
      logic        e1;
      logic        es;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
   } wb_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        iss_valid;
   logic [4:0]  iss_rs1, iss_rs2, iss_rd;
   logic        stall;
   logic        req0_valid, req1_valid;
   logic [4:0]  req0_rd, req1_rd;
   logic [31:0] req0_data, req1_data;
   logic        req0_ready, req1_ready;
   logic        reg_write;
   logic [4:0]  wr_addr;
   logic [31:0] write_data_reg_file;

   int checks   = 0;
   int failures = 0;

   vec_t vecs[$];
   wb_t  sb[$];

   always #5 clk = ~clk;

   rf_wb_arbiter #(.XLEN(32)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .iss_valid           (iss_valid),
      .iss_rs1             (iss_rs1),
      .iss_rs2             (iss_rs2),
      .iss_rd              (iss_rd),
      .stall               (stall),
      .req0_valid          (req0_valid),
      .req0_rd             (req0_rd),
      .req0_data           (req0_data),
      .req1_valid          (req1_valid),
      .req1_rd             (req1_rd),
      .req1_data           (req1_data),
      .req0_ready          (req0_ready),
      .req1_ready          (req1_ready),
      .reg_write           (reg_write),
      .wr_addr             (wr_addr),
      .write_data_reg_file (write_data_reg_file)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t v(input logic rs, input logic a0v, input logic [4:0] a0rd,
                              input logic [31:0] a0d, input logic a1v, input logic [4:0] a1rd,
                              input logic [31:0] a1d, input logic ivv, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [4:0] d, input logic x0,
                              input logic x1, input logic xs);
      vec_t t;
      t.rst = rs; t.r0v = a0v; t.r0rd = a0rd; t.r0d = a0d;
      t.r1v = a1v; t.r1rd = a1rd; t.r1d = a1d;
      t.iv = ivv; t.rs1 = s1; t.rs2 = s2; t.rd = d;
      t.e0 = x0; t.e1 = x1; t.es = xs;
      return t;
   endfunction

   task automatic check_wb(input int idx);
      wb_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check($sformatf("v%0d reg_write", idx), 64'(reg_write), 64'(e.we));
         check($sformatf("v%0d wr_addr", idx), 64'(wr_addr), 64'(e.addr));
         check($sformatf("v%0d wdata", idx), 64'(write_data_reg_file), 64'(e.data));
      end
   endtask

   initial begin
      wb_t         e;
      logic [4:0]  m_addr = 5'd0;
      logic [31:0] m_data = 32'd0;

      // Reset with all inputs active: readys and stall must stay low.
      vecs.push_back(v(1, 1,5,32'h1, 1,6,32'h2, 1,1,2,3, 0,0,0));
      vecs.push_back(v(1, 1,5,32'h1, 1,6,32'h2, 1,1,2,3, 0,0,0));
      // Single req0 write, then idle.
      vecs.push_back(v(0, 1,5,32'hDEADBEEF, 0,0,0, 0,0,0,0, 1,0,0));
      vecs.push_back(v(0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0));
      vecs.push_back(v(0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0));
      // req1 alone, so the next tie goes to req0.
      vecs.push_back(v(0, 0,0,0, 1,9,32'h99, 0,0,0,0, 0,1,0));
      // Contention: strict alternation 0,1,0,1 with back-to-back writes.
      vecs.push_back(v(0, 1,10,32'hA0, 1,20,32'hB0, 0,0,0,0, 1,0,0));
      vecs.push_back(v(0, 1,11,32'hA1, 1,20,32'hB0, 0,0,0,0, 0,1,0));
      vecs.push_back(v(0, 1,11,32'hA1, 1,21,32'hB1, 0,0,0,0, 1,0,0));
      vecs.push_back(v(0, 1,12,32'hA2, 1,21,32'hB1, 0,0,0,0, 0,1,0));
      vecs.push_back(v(0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0));
      // RAW on x7: issue, stall until two cycles after the req1 handshake.
      vecs.push_back(v(0, 0,0,0, 0,0,0, 1,0,0,7, 0,0,0));
      for (int k = 0; k < 4; k++)
         vecs.push_back(v(0, 0,0,0, 0,0,0, 1,7,0,0, 0,0,1));
      vecs.push_back(v(0, 0,0,0, 1,7,32'h77, 1,7,0,0, 0,1,1));
      vecs.push_back(v(0, 0,0,0, 0,0,0, 1,7,0,0, 0,0,1));
      vecs.push_back(v(0, 0,0,0, 0,0,0, 1,7,0,0, 0,0,0));
      // x0: no pending bit, consumed grant with no write.
      vecs.push_back(v(0, 1,0,32'h123, 0,0,0, 1,0,0,0, 1,0,0));
      vecs.push_back(v(0, 0,0,0, 0,0,0, 1,0,0,0, 0,0,0));
      // WAW on x3, rs2 hazard, then reset mid-flight.
      vecs.push_back(v(0, 0,0,0, 0,0,0, 1,0,0,3, 0,0,0));
      vecs.push_back(v(0, 0,0,0, 0,0,0, 1,0,0,3, 0,0,1));
      vecs.push_back(v(0, 0,0,0, 0,0,0, 1,0,3,0, 0,0,1));
      vecs.push_back(v(1, 1,3,32'h33, 0,0,0, 1,3,0,0, 0,0,0));
      // After reset: pending clear, first tie goes to req0.
      vecs.push_back(v(0, 1,3,32'h33, 1,4,32'h44, 1,3,0,3, 1,0,0));
      vecs.push_back(v(0, 0,0,0, 1,4,32'h44, 1,3,0,0, 0,1,1));
      vecs.push_back(v(0, 0,0,0, 0,0,0, 1,3,0,0, 0,0,0));
      vecs.push_back(v(0, 0,0,0, 0,0,0, 0,0,0,0, 0,0,0));

      rst = 1'b1; iss_valid = 1'b0; iss_rs1 = '0; iss_rs2 = '0; iss_rd = '0;
      req0_valid = 1'b0; req0_rd = '0; req0_data = '0;
      req1_valid = 1'b0; req1_rd = '0; req1_data = '0;
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         check_wb(i);
         rst        = vecs[i].rst;
         req0_valid = vecs[i].r0v; req0_rd = vecs[i].r0rd; req0_data = vecs[i].r0d;
         req1_valid = vecs[i].r1v; req1_rd = vecs[i].r1rd; req1_data = vecs[i].r1d;
         iss_valid  = vecs[i].iv;  iss_rs1 = vecs[i].rs1;  iss_rs2 = vecs[i].rs2;
         iss_rd     = vecs[i].rd;
         #1;
         check($sformatf("v%0d req0_ready", i), 64'(req0_ready), 64'(vecs[i].e0));
         check($sformatf("v%0d req1_ready", i), 64'(req1_ready), 64'(vecs[i].e1));
         check($sformatf("v%0d stall", i), 64'(stall), 64'(vecs[i].es));
         if (vecs[i].rst) begin
            e.we = 1'b0; e.addr = 5'd0; e.data = 32'd0;
         end else if (vecs[i].e0) begin
            e.we = (vecs[i].r0rd != 5'd0); e.addr = vecs[i].r0rd; e.data = vecs[i].r0d;
         end else if (vecs[i].e1) begin
            e.we = (vecs[i].r1rd != 5'd0); e.addr = vecs[i].r1rd; e.data = vecs[i].r1d;
         end else begin
            e.we = 1'b0; e.addr = m_addr; e.data = m_data;
         end
         m_addr = e.addr;
         m_data = e.data;
         sb.push_back(e);
         @(posedge clk);
         #1;
      end
      check_wb(vecs.size());

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback controller for the 32x32 register file in the RISC-V core. It shares the register file's single write port between two writeback requesters (requester 0: ALU/CSR result, requester 1: load data from the memory unit) using round-robin arbitration with valid/ready handshakes. It also keeps a 32-entry pending-write scoreboard that stalls instruction issue on read-after-write and write-after-write hazards until the producing write has actually committed. Its registered outputs drive the register file's `reg_write`, destination address and `write_data_reg_file` inputs directly.

## Interface
- `XLEN`, 32: data width of the write path.
- `clk`  in  1  rising-edge clock, shared with the register file.
- `rst`  in  1  synchronous, active-high reset.
- `iss_valid`  in  1  decode presents an instruction this cycle.
- `iss_rs1`, `iss_rs2`  in  5 each  source register indices of the presented instruction.
- `iss_rd`  in  5  destination of the presented instruction; 0 means no write.
- `stall`  out  1  combinational; the issue is refused this cycle.
- `req0_valid`, `req1_valid`  in  1 each  writeback request.
- `req0_rd`, `req1_rd`  in  5 each  destination register.
- `req0_data`, `req1_data`  in  XLEN each  writeback data.
- `req0_ready`, `req1_ready`  out  1 each  combinational grant; the handshake completes on valid&&ready.
- `reg_write`  out  1  registered write enable to the register file.
- `wr_addr`  out  5  registered write address.
- `write_data_reg_file`  out  XLEN  registered write data.

## Operation
- State:
  - `pending[31:0]` scoreboard; bit 0 is hard-wired to 0.
  - `last_grant` (1 bit).
  - Output register `{reg_write, wr_addr, write_data_reg_file}`.
- Stall:
  - `stall = iss_valid && (pending[iss_rs1] | pending[iss_rs2] | pending[iss_rd])`.
  - Computed from the registered `pending` only; there is no bypass from writes in flight.
- Issue accept:
  - Occurs when `iss_valid && !stall`.
  - If `iss_rd != 0`, sets `pending[iss_rd]` at the clock edge.
- Arbitration (one grant per cycle, combinational):
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant `!last_grant`.
  - `last_grant` updates to the granted index only when a grant occurs; it holds otherwise.
  - Ready is asserted only to the granted requester.
- Handshake at edge N (grant g):
  - Output register loads `reg_write = (rd_g != 0)`, `wr_addr = rd_g`, `write_data_reg_file = data_g`.
  - A grant with `rd = 0` is consumed (ready asserted) but produces `reg_write = 0`.
- No handshake:
  - Output register loads `reg_write = 0`.
  - `wr_addr` and `write_data_reg_file` hold their previous values.
- Scoreboard clear: at the edge where the output register holds `reg_write = 1`, i.e. the edge on which the register file commits the write, `pending[wr_addr]` clears.
- Same-index set and clear cannot coincide, because the issue path stalls on WAW. If they did, the set wins.
- Requesters must not drop valid or change rd/data while valid && !ready. A violation is undefined, with no data corruption beyond that request.

## Timing
- Reset (rst = 1 at an edge):
  - `pending = 0`, `last_grant = 1` (req0 wins the first tie).
  - `reg_write = 0`, `wr_addr = 0`, `write_data_reg_file = 0`.
  - `stall` and both readys are combinationally 0 while `rst` is high.
  - Reset mid-operation drops any request in flight and any pending writes; the requesters must re-present.
- Writeback latency:
  - Handshake in cycle N: `reg_write` is high during cycle N+1 and the register file commits at the end of N+1.
  - The pending bit clears at that same edge.
  - A dependent instruction's `stall` deasserts in cycle N+2, the first cycle the new value is readable.
- Issue to stall:
  - Issue of rd = R accepted in cycle N: an instruction in cycle N+1 reading R stalls.
- Throughput:
  - One write per cycle, back-to-back, with no bubble.
  - Under continuous contention the two requesters strictly alternate.

## Test plan
- Reset then single request: rst high 2 cycles, then req0 (rd = 5, data = 0xDEADBEEF).
  - req0_ready = 1 in the same cycle.
  - Next cycle `reg_write = 1`, `wr_addr = 5`, data = 0xDEADBEEF.
  - The cycle after, `reg_write = 0`.
- Contention: req0 and req1 held valid for 4 cycles with distinct rd.
  - Grants go 0,1,0,1; `wr_addr` follows the same order one cycle later.
  - `reg_write` stays high for 4 consecutive cycles.
- RAW stall: issue rd = 7 in cycle 0, then present rs1 = 7 from cycle 1.
  - `stall = 1` until the req1 (rd = 7) handshake in cycle 5.
  - `stall` remains 1 in cycle 6 and is 0 in cycle 7.
- x0 handling: issue with rd = 0, then req0 with rd = 0.
  - No pending bit is set and no stall results.
  - req0_ready = 1 but `reg_write` stays 0.
- WAW and reset mid-flight: issue rd = 3, then present rd = 3 again.
  - The second issue stalls.
  - Assert rst: `pending` clears and `stall` drops to 0 in the cycle after rst deasserts.
  - Any handshake pending at reset produces no `reg_write`.
